ps2_kbd_wb: RTL and testbench

PS2_KBD_WB -- requirements
Module: ps2_kbd_wb

---
 rtl/ps2_kbd_wb.sv | 134 +++++++++++++
 tb/tb_ps2_kbd_wb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_wb.sv
// ps2_kbd_wb: PS/2 keyboard receiver with a scan-code FIFO behind a Wishbone slave.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   PS2C, PS2D    raw PS/2 clock and data pins
//   STB, WE       Wishbone strobe and write enable
//   ADDR          byte address, ADDR[2] selects DATA (0) or STATUS (1)
//   DAT_I         write data, bit 0 of a STATUS write clears ovf/perr
//   DAT_O, ACK    registered read data and single-cycle acknowledge
//   irq           registered FIFO-non-empty indication
module ps2_kbd_wb #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PS2C,
    input  logic        PS2D,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
    state_t        r_state, w_next;
    logic          r_c_meta, r_c_sync, r_c_prev, r_d_meta, r_d_sync;
    logic [2:0]    r_bit;
    logic [7:0]    r_sh;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          r_push_v, r_perr_set;
    logic [7:0]    r_push_d;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_ovf, r_perr;
    logic          w_fall, w_to, w_stop, w_ok;
    logic          w_acc, w_ne, w_pop, w_full, w_wr, w_ovf_set, w_clr;
    logic [7:0]    w_head;
    logic [31:0]   w_cnt32, w_status, w_data;
    logic          w_unused;
    // Edge is taken between the last two synchronized samples of PS2C.
    assign w_fall = r_c_prev & ~r_c_sync;
    // A partial frame is abandoned once the line stalls for TIMEOUT cycles.
    assign w_to   = (r_state != S_IDLE) & ~w_fall & (r_tmo == TW'(TIMEOUT - 1));
    assign w_stop = w_fall & (r_state == S_STOP);
    assign w_ok   = r_d_sync & (^{r_par, r_sh});
    always_comb begin
        w_next = r_state;
        if (w_to)
            w_next = S_IDLE;
        else if (w_fall)
            case (r_state)
                S_IDLE:   w_next = r_d_sync ? S_IDLE : S_DATA;
                S_DATA:   w_next = (r_bit == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_next = S_STOP;
                default:  w_next = S_IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_c_meta   <= 1'b1;
            r_c_sync   <= 1'b1;
            r_c_prev   <= 1'b1;
            r_d_meta   <= 1'b1;
            r_d_sync   <= 1'b1;
            r_bit      <= '0;
            r_sh       <= '0;
            r_par      <= 1'b0;
            r_tmo      <= '0;
            r_push_v   <= 1'b0;
            r_push_d   <= '0;
            r_perr_set <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_c_meta   <= PS2C;
            r_c_sync   <= r_c_meta;
            r_c_prev   <= r_c_sync;
            r_d_meta   <= PS2D;
            r_d_sync   <= r_d_meta;
            r_bit      <= (r_state != S_DATA || w_to) ? 3'd0 : w_fall ? r_bit + 3'd1 : r_bit;
            r_sh       <= (w_fall && r_state == S_DATA) ? {r_d_sync, r_sh[7:1]} : r_sh;
            r_par      <= (w_fall && r_state == S_PARITY) ? r_d_sync : r_par;
            r_tmo      <= (r_state == S_IDLE || w_fall) ? '0 : r_tmo + 1'b1;
            r_push_v   <= w_stop & w_ok;
            r_push_d   <= r_sh;
            r_perr_set <= w_stop & ~w_ok;
        end
    end
    assign w_acc     = STB & ~ACK;
    assign w_ne      = r_cnt != '0;
    assign w_head    = w_ne ? r_mem[r_rp] : 8'h00;
    assign w_pop     = w_acc & ~WE & ~ADDR[2] & w_ne;
    assign w_full    = r_cnt == CW'(FIFO_DEPTH);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_wr      = r_push_v & (~w_full | w_pop);
    assign w_ovf_set = r_push_v & w_full & ~w_pop;
    assign w_clr     = w_acc & WE & ADDR[2] & DAT_I[0];
    assign w_cnt32   = 32'(r_cnt);
    assign w_status  = {25'b0, r_ovf, r_perr, w_cnt32[4:0]};
    assign w_data    = {23'b0, w_ne, w_head};
    assign w_unused  = &{1'b0, ADDR[31:3], ADDR[1:0], DAT_I[31:1], w_cnt32[31:5]};
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= r_push_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_perr <= 1'b0;
            ACK    <= 1'b0;
            DAT_O  <= '0;
            irq    <= 1'b0;
        end else begin
            r_wp   <= w_wr ? r_wp + 1'b1 : r_wp;
            r_rp   <= w_pop ? r_rp + 1'b1 : r_rp;
            r_cnt  <= r_cnt + CW'(w_wr) - CW'(w_pop);
            r_ovf  <= w_ovf_set | (r_ovf & ~w_clr);
            r_perr <= r_perr_set | (r_perr & ~w_clr);
            ACK    <= w_acc;
            DAT_O  <= w_acc ? (WE ? 32'h0 : ADDR[2] ? w_status : w_data) : DAT_O;
            irq    <= w_ne;
        end
    end
endmodule

// File: tb/tb_ps2_kbd_wb.sv
// tb_ps2_kbd_wb: directed self-checking bench for the PS/2 keyboard Wishbone slave.
module tb_ps2_kbd_wb;
    localparam int TMO = 300;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PS2C = 1'b1;
    logic        PS2D = 1'b1;
    logic        STB = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] ADDR = '0;
    logic [31:0] DAT_I = '0;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        irq;
    int          vectors = 0;
    int          errors = 0;

    ps2_kbd_wb #(.FIFO_DEPTH(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D), .STB(STB), .WE(WE),
        .ADDR(ADDR), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK(ACK), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic ps2_bit(input logic b);
        PS2D = b;
        repeat (4) @(negedge clk);
        PS2C = 1'b0;
        repeat (4) @(negedge clk);
        PS2C = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        repeat (6) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    task automatic bus(input logic we, input logic a2, input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(negedge clk);
        STB = 1'b1; WE = we; ADDR = {29'b0, a2, 2'b0}; DAT_I = wd; n = 0;
        do begin @(negedge clk); n++; end while (!ACK && n < 8);
        rd = DAT_O;
        STB = 1'b0; WE = 1'b0;
        vectors++;
        if (ACK !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL ack_latency: cycles=%0d ACK=%b, required 1 cycle ACK=1", n, ACK);
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({DAT_O, ACK, irq} !== 34'h0) begin
            errors++;
            $display("FAIL reset_outputs: DAT_O=%h ACK=%b irq=%b, required 0", DAT_O, ACK, irq);
        end
        rst = 1'b0;
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL reset_status: got %h required 00000000", rd); end
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        send_frame(8'h1C, 1'b0, 1'b1);
        vectors++;
        if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_set: got %b required 1", irq); end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h11C) begin errors++; $display("FAIL basic_read: got %h required 0000011c", rd); end
        @(negedge clk);
        vectors++;
        if (ACK !== 1'b0) begin errors++; $display("FAIL basic_ack_width: ACK=%b required 0", ACK); end
        vectors++;
        if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_fall: got %b required 0", irq); end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL basic_empty_read: got %h required 00000000", rd); end
    endtask

    task automatic test_parity_error;
        logic [31:0] rd;
        send_frame(8'h1C, 1'b1, 1'b1);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h20) begin errors++; $display("FAIL perr_status: got %h required 00000020", rd); end
        bus(1'b1, 1'b1, 32'h1, rd);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL perr_clear: got %h required 00000000", rd); end
    endtask

    task automatic test_overflow;
        logic [31:0] rd;
        for (int i = 1; i <= 17; i++) send_ok(8'(i));
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h50) begin errors++; $display("FAIL ovf_status: got %h required 00000050", rd); end
        for (int i = 1; i <= 16; i++) begin
            bus(1'b0, 1'b0, 32'h0, rd);
            vectors++;
            if (rd !== (32'h100 | i)) begin
                errors++;
                $display("FAIL ovf_read_%0d: got %h required %h", i, rd, 32'h100 | i);
            end
        end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ovf_read_17: got %h required 00000000", rd); end
        bus(1'b1, 1'b1, 32'h1, rd);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL ovf_clear: got %h required 00000000", rd); end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (TMO + 10) @(negedge clk);
        send_ok(8'hF0);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h1) begin errors++; $display("FAIL timeout_status: got %h required 00000001", rd); end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h1F0) begin errors++; $display("FAIL timeout_read: got %h required 000001f0", rd); end
    endtask

    task automatic test_full_pop;
        logic [31:0] rd;
        logic [7:0]  b;
        for (int i = 0; i < 16; i++) send_ok(8'h20 + 8'(i));
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h10) begin errors++; $display("FAIL full_status: got %h required 00000010", rd); end
        b = 8'h77;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b);
        PS2D = 1'b1;
        repeat (4) @(negedge clk);
        PS2C = 1'b0;
        // push lands on the 4th rising edge after the fall; the pop is aimed at that edge
        repeat (2) @(negedge clk);
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h120) begin errors++; $display("FAIL full_pop_read: got %h required 00000120", rd); end
        repeat (2) @(negedge clk);
        PS2C = 1'b1;
        repeat (6) @(negedge clk);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h10) begin errors++; $display("FAIL full_pop_status: got %h required 00000010", rd); end
        for (int i = 1; i < 16; i++) begin
            bus(1'b0, 1'b0, 32'h0, rd);
            vectors++;
            if (rd !== (32'h120 + i)) begin
                errors++;
                $display("FAIL full_pop_drain_%0d: got %h required %h", i, rd, 32'h120 + i);
            end
        end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h177) begin errors++; $display("FAIL full_pop_tail: got %h required 00000177", rd); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] rd;
        send_ok(8'h33);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({DAT_O, ACK, irq} !== 34'h0) begin
            errors++;
            $display("FAIL midreset_outputs: DAT_O=%h ACK=%b irq=%b, required 0", DAT_O, ACK, irq);
        end
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h0) begin errors++; $display("FAIL midreset_status: got %h required 00000000", rd); end
        send_ok(8'h5A);
        bus(1'b1, 1'b0, 32'hAB, rd);
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h1) begin errors++; $display("FAIL write_data_ignored: got %h required 00000001", rd); end
        bus(1'b0, 1'b1, 32'h0, rd);
        vectors++;
        if (rd !== 32'h1) begin errors++; $display("FAIL status_no_side_effect: got %h required 00000001", rd); end
        bus(1'b0, 1'b0, 32'h0, rd);
        vectors++;
        if (rd !== 32'h15A) begin errors++; $display("FAIL midreset_read: got %h required 0000015a", rd); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity_error;
        test_overflow;
        test_timeout;
        test_full_pop;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
